// File: rtl/ecc_2d_decoder.sv
// ecc_2d_decoder
//   Receive-side decoder for the 2D row/column parity code. It computes row,
//   column and corner syndromes from a received codeword and corrects any
//   single-bit error, whether in data or in parity. It returns the payload
//   through a two-stage valid/ready pipeline. Uncorrectable words are dropped
//   and reported with a one-cycle nack pulse.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   in_valid   : code_in carries a codeword
//   in_ready   : stage can accept code_in this cycle (combinational)
//   code_in    : received codeword, (COL_NUM+1)*(ROW_NUM+1) bits
//   out_valid  : data_out holds a delivered word
//   out_ready  : consumer accepts data_out
//   data_out   : corrected payload, COL_NUM*ROW_NUM bits
//   corrected  : delivered word had one bit fixed (qualified by out_valid)
//   nack       : one-cycle pulse, an uncorrectable word was dropped
//   cnt_clear  : synchronous clear of both error counters
//   corr_cnt   : saturating count of corrected words
//   uncorr_cnt : saturating count of dropped words
module ecc_2d_decoder #(
  parameter int COL_NUM   = 4,
  parameter int ROW_NUM   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [(COL_NUM+1)*(ROW_NUM+1)-1:0]     code_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COL_NUM*ROW_NUM-1:0]             data_out,
  output logic                                   corrected,
  output logic                                   nack,
  input  logic                                   cnt_clear,
  output logic [CNT_WIDTH-1:0]                   corr_cnt,
  output logic [CNT_WIDTH-1:0]                   uncorr_cnt
);

  localparam int CW      = (COL_NUM + 1) * (ROW_NUM + 1);
  localparam int DW      = COL_NUM * ROW_NUM;
  localparam int CP_BASE = ROW_NUM * (COL_NUM + 1);   // first column-parity bit
  localparam int UC_BIT  = CP_BASE + COL_NUM;          // corner parity bit
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  // Payload bits, stripped of the interleaved parity bits.
  function automatic logic [DW-1:0] get_payload(input logic [CW-1:0] cw);
    logic [DW-1:0] p;
    p = {DW{1'b0}};
    for (int i = 0; i < ROW_NUM; i++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        p[i*COL_NUM+j] = cw[i*(COL_NUM+1)+j];
      end
    end
    return p;
  endfunction

  // Row syndromes: parity of each data row including its row parity bit.
  function automatic logic [ROW_NUM-1:0] row_syn(input logic [CW-1:0] cw);
    logic [ROW_NUM-1:0] s;
    s = {ROW_NUM{1'b0}};
    for (int i = 0; i < ROW_NUM; i++) begin
      s[i] = cw[(i+1)*(COL_NUM+1)-1];
      for (int j = 0; j < COL_NUM; j++) begin
        s[i] = s[i] ^ cw[i*(COL_NUM+1)+j];
      end
    end
    return s;
  endfunction

  // Column syndromes: parity of each data column including its column parity bit.
  function automatic logic [COL_NUM-1:0] col_syn(input logic [CW-1:0] cw);
    logic [COL_NUM-1:0] s;
    s = {COL_NUM{1'b0}};
    for (int j = 0; j < COL_NUM; j++) begin
      s[j] = cw[CP_BASE+j];
      for (int i = 0; i < ROW_NUM; i++) begin
        s[j] = s[j] ^ cw[i*(COL_NUM+1)+j];
      end
    end
    return s;
  endfunction

  // Corner syndrome: column parity bits checked against the corner bit.
  function automatic logic corner_syn(input logic [CW-1:0] cw);
    logic s;
    s = cw[UC_BIT];
    for (int j = 0; j < COL_NUM; j++) begin
      s = s ^ cw[CP_BASE+j];
    end
    return s;
  endfunction

  // Stage 1 keeps only the payload: once the syndromes are known, the parity
  // bits carry no further information for correction.
  logic                s1_valid_q, s1_valid_d;
  logic [DW-1:0]       s1_data_q, s1_data_d;
  logic [ROW_NUM-1:0]  s1_sr_q, s1_sr_d;
  logic [COL_NUM-1:0]  s1_sc_q, s1_sc_d;
  logic                s1_sk_q, s1_sk_d;

  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       data_q, data_d;
  logic                corr_q, corr_d;
  logic                nack_q, nack_d;
  logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_WIDTH-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic                advance_s;
  logic                in_ready_s;
  logic                take_s;
  logic                sr_none_s, sc_none_s, sr_one_s, sc_one_s;
  logic                clean_s, data_err_s, fixed_s, uncorr_s;
  logic [DW-1:0]       flip_mask_s;

  assign advance_s  = !out_valid_q || out_ready;
  assign in_ready_s = !s1_valid_q || advance_s;
  assign take_s     = advance_s && s1_valid_q;

  // Stage-1 next state: load a new word whenever the stage is free or draining.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sr_d    = s1_sr_q;
    s1_sc_d    = s1_sc_q;
    s1_sk_d    = s1_sk_q;
    if (in_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = get_payload(code_in);
        s1_sr_d   = row_syn(code_in);
        s1_sc_d   = col_syn(code_in);
        s1_sk_d   = corner_syn(code_in);
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Syndrome classification of the word sitting in stage 1.
  always_comb begin
    sr_none_s  = (s1_sr_q == {ROW_NUM{1'b0}});
    sc_none_s  = (s1_sc_q == {COL_NUM{1'b0}});
    sr_one_s   = ($countones(s1_sr_q) == 32'd1);
    sc_one_s   = ($countones(s1_sc_q) == 32'd1);
    clean_s    = sr_none_s && sc_none_s && !s1_sk_q;
    data_err_s = sr_one_s && sc_one_s && !s1_sk_q;
    // Single parity-bit errors (row, column, corner) leave the payload intact.
    fixed_s    = data_err_s
               || (sr_one_s  && sc_none_s && !s1_sk_q)
               || (sr_none_s && sc_one_s  &&  s1_sk_q)
               || (sr_none_s && sc_none_s &&  s1_sk_q);
    uncorr_s   = !(clean_s || fixed_s);
    // Outer product of the one-hot syndromes marks the failing data bit.
    flip_mask_s = {DW{1'b0}};
    for (int i = 0; i < ROW_NUM; i++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        flip_mask_s[i*COL_NUM+j] = s1_sr_q[i] & s1_sc_q[j];
      end
    end
  end

  // Stage-2 next state, nack pulse and saturating counters.
  always_comb begin
    out_valid_d  = out_valid_q;
    data_d       = data_q;
    corr_d       = corr_q;
    nack_d       = take_s && uncorr_s;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (advance_s) begin
      if (s1_valid_q && !uncorr_s) begin
        out_valid_d = 1'b1;
        data_d      = s1_data_q ^ (data_err_s ? flip_mask_s : {DW{1'b0}});
        corr_d      = fixed_s;
      end else begin
        // Empty stage 1 or a dropped word: the old output has been consumed.
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (cnt_clear) begin
      corr_cnt_d   = CNT_ZERO;
      uncorr_cnt_d = CNT_ZERO;
    end else begin
      if (take_s && fixed_s && (corr_cnt_q != CNT_MAX)) begin
        corr_cnt_d = corr_cnt_q + CNT_ONE;
      end else begin
        corr_cnt_d = corr_cnt_q;
      end
      if (take_s && uncorr_s && (uncorr_cnt_q != CNT_MAX)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
      end else begin
        uncorr_cnt_d = uncorr_cnt_q;
      end
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {DW{1'b0}};
      s1_sr_q    <= {ROW_NUM{1'b0}};
      s1_sc_q    <= {COL_NUM{1'b0}};
      s1_sk_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sr_q    <= s1_sr_d;
      s1_sc_q    <= s1_sc_d;
      s1_sk_q    <= s1_sk_d;
    end
  end

  // Stage-2 output registers and link-health counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      data_q       <= {DW{1'b0}};
      corr_q       <= 1'b0;
      nack_q       <= 1'b0;
      corr_cnt_q   <= CNT_ZERO;
      uncorr_cnt_q <= CNT_ZERO;
    end else begin
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      corr_q       <= corr_d;
      nack_q       <= nack_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign corrected  = corr_q;
  assign nack       = nack_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_2d_decoder.sv
// tb_ecc_2d_decoder
//   Self-checking bench for ecc_2d_decoder: directed table of single-word
//   vectors, hand-written pipeline sequences (back-to-back, back-pressure,
//   counter saturation/clear, reset mid-stall) and a randomized run against a
//   behavioural reference decoder with a scoreboard queue.
module tb_ecc_2d_decoder;

  localparam int C  = 4;
  localparam int R  = 4;
  localparam int CW = (C + 1) * (R + 1);
  localparam int DW = C * R;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] code_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          corrected;
  logic          nack;
  logic          cnt_clear;
  logic [7:0]    corr_cnt;
  logic [7:0]    uncorr_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [DW-1:0] sat_data_out;
  logic          sat_corrected;
  logic          sat_nack;
  logic [1:0]    sat_corr_cnt;
  logic [1:0]    sat_uncorr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_2d_decoder #(.COL_NUM(C), .ROW_NUM(R), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .corrected(corrected), .nack(nack),
    .cnt_clear(cnt_clear), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  // Second instance with 2-bit counters shares all inputs.
  ecc_2d_decoder #(.COL_NUM(C), .ROW_NUM(R), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .code_in(code_in), .out_valid(sat_out_valid), .out_ready(out_ready),
    .data_out(sat_data_out), .corrected(sat_corrected), .nack(sat_nack),
    .cnt_clear(cnt_clear), .corr_cnt(sat_corr_cnt), .uncorr_cnt(sat_uncorr_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: data in a grid, parity at row ends, column parity row, corner.
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] p);
    logic [CW-1:0] cw;
    logic b;
    cw = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        cw[i*(C+1)+j] = p[i*C+j];
    for (int i = 0; i < R; i++) begin
      b = 1'b0;
      for (int j = 0; j < C; j++) b = b ^ p[i*C+j];
      cw[(i+1)*(C+1)-1] = b;
    end
    for (int j = 0; j < C; j++) begin
      b = 1'b0;
      for (int i = 0; i < R; i++) b = b ^ p[i*C+j];
      cw[R*(C+1)+j] = b;
    end
    cw[R*(C+1)+C] = ^p;
    return cw;
  endfunction

  function automatic logic [CW-1:0] bitmask(input int pos);
    logic [CW-1:0] m;
    m = '0;
    if (pos >= 0) m[pos] = 1'b1;
    return m;
  endfunction

  // Reference decoder: counts failing rows/columns and classifies by the rules.
  function automatic void ref_decode(input logic [CW-1:0] cw, output bit drop,
                                     output bit corr, output logic [DW-1:0] data);
    int nr, nc, ri, cj;
    bit s, sk;
    nr = 0; nc = 0; ri = 0; cj = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        data[i*C+j] = cw[i*(C+1)+j];
    for (int i = 0; i < R; i++) begin
      s = cw[(i+1)*(C+1)-1];
      for (int j = 0; j < C; j++) s = s ^ cw[i*(C+1)+j];
      if (s) begin nr++; ri = i; end
    end
    for (int j = 0; j < C; j++) begin
      s = cw[R*(C+1)+j];
      for (int i = 0; i < R; i++) s = s ^ cw[i*(C+1)+j];
      if (s) begin nc++; cj = j; end
    end
    sk = cw[R*(C+1)+C];
    for (int j = 0; j < C; j++) sk = sk ^ cw[R*(C+1)+j];
    drop = 1'b0;
    corr = 1'b1;
    if (nr == 0 && nc == 0 && !sk) corr = 1'b0;
    else if (nr == 1 && nc == 1 && !sk) data[ri*C+cj] = ~data[ri*C+cj];
    else if (nr == 1 && nc == 0 && !sk) corr = 1'b1;
    else if (nr == 0 && nc == 1 && sk) corr = 1'b1;
    else if (nr == 0 && nc == 0 && sk) corr = 1'b1;
    else begin drop = 1'b1; corr = 1'b0; end
  endfunction

  typedef struct {
    logic [DW-1:0] payload;
    int            f0;
    int            f1;
    bit            clr;
    logic [DW-1:0] exp_data;
    bit            exp_corr;
    bit            exp_drop;
    int            exp_cc;
    int            exp_uc;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  // Safety net: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] cs[3];
    logic [DW-1:0] bw[4];
    logic [DW-1:0] got[$];
    logic [DW:0]   expq[$];
    logic [DW:0]   e;
    logic [DW-1:0] rp, rdata, prev_data;
    logic [CW-1:0] rcw;
    bit            rdrop, rcorr, stall_prev, prev_corr, acc, del;
    int            idx, p0, p1, rr, exp_cc, exp_uc, nack_seen, ov_seen;

    vt[0]  = '{16'hA5A5, -1, -1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 0, 0};
    vt[1]  = '{16'h0000, -1, -1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 0};
    vt[2]  = '{16'hFFFF, -1, -1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 0};
    vt[3]  = '{16'hA5A5,  6, -1, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1, 0};
    vt[4]  = '{16'h1234, 14, -1, 1'b1, 16'h1234, 1'b1, 1'b0, 1, 0};
    vt[5]  = '{16'h1234, 23, -1, 1'b0, 16'h1234, 1'b1, 1'b0, 2, 0};
    vt[6]  = '{16'h1234, 24, -1, 1'b0, 16'h1234, 1'b1, 1'b0, 3, 0};
    vt[7]  = '{16'h1234,  0,  1, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 1};
    vt[8]  = '{16'h5A5A, -1, -1, 1'b0, 16'h5A5A, 1'b0, 1'b0, 3, 1};
    vt[9]  = '{16'h0001,  0, -1, 1'b0, 16'h0001, 1'b1, 1'b0, 4, 1};
    vt[10] = '{16'h8000, 18, -1, 1'b0, 16'h8000, 1'b1, 1'b0, 5, 1};

    // ---------------- reset state
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0; code_in = '0;
    tick(); tick();
    check("rst_outputs", {out_valid, corrected, nack, data_out}, '0);
    check("rst_counters", {corr_cnt, uncorr_cnt}, '0);
    #2 reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1'b1);

    // ---------------- clean back-to-back stream
    cs[0] = 16'hA5A5; cs[1] = 16'h0000; cs[2] = 16'hFFFF;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      if (k < 3) code_in = encode(cs[k]);
      #1;
      if (k == 1) check("clean_latency", out_valid, 1'b0);
      if (k >= 2 && k <= 4)
        check($sformatf("clean_word%0d", k - 2), {out_valid, corrected, data_out}, {1'b1, 1'b0, cs[k-2]});
      if (k == 5) check("clean_empty", out_valid, 1'b0);
      check($sformatf("clean_nack%0d", k), nack, 1'b0);
      tick();
    end
    check("clean_counters", {corr_cnt, uncorr_cnt}, '0);

    // ---------------- table of single-word vectors
    for (int v = 0; v < NV; v++) begin
      if (vt[v].clr) begin cnt_clear = 1'b1; tick(); cnt_clear = 1'b0; end
      code_in  = encode(vt[v].payload) ^ bitmask(vt[v].f0) ^ bitmask(vt[v].f1);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_in_ready", v), in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      check($sformatf("tbl%0d_in_s1", v), {out_valid, nack}, 2'b00);
      tick();
      #1;
      if (vt[v].exp_drop) begin
        check($sformatf("tbl%0d_drop", v), {out_valid, nack}, 2'b01);
        tick();
        #1;
        check($sformatf("tbl%0d_nack_end", v), {out_valid, nack}, 2'b00);
      end else begin
        check($sformatf("tbl%0d_data", v), {out_valid, nack, corrected, data_out},
              {1'b1, 1'b0, vt[v].exp_corr, vt[v].exp_data});
        tick();
        #1;
        check($sformatf("tbl%0d_drain", v), out_valid, 1'b0);
      end
      check($sformatf("tbl%0d_corr_cnt", v), corr_cnt, vt[v].exp_cc);
      check($sformatf("tbl%0d_uncorr_cnt", v), uncorr_cnt, vt[v].exp_uc);
    end

    // ---------------- back-pressure: 4 words, consumer stalled 5 cycles
    bw[0] = 16'h1111; bw[1] = 16'h2222; bw[2] = 16'h3333; bw[3] = 16'h4444;
    idx = 0;
    got.delete();
    for (int cyc = 0; cyc < 24; cyc++) begin
      in_valid  = (idx < 4);
      if (idx < 4) code_in = encode(bw[idx]);
      out_ready = (cyc >= 7);
      #1;
      if (cyc >= 2 && cyc <= 6)
        check($sformatf("bp_stall%0d", cyc), {in_ready, out_valid, data_out}, {1'b0, 1'b1, bw[0]});
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) got.push_back(data_out);
      if (acc) idx++;
      tick();
    end
    out_ready = 1'b1;
    check("bp_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) check($sformatf("bp_word%0d", k), got[k], bw[k]);

    // ---------------- counter saturation (2-bit instance) and clear priority
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rp = DW'(k * 16'h1111 + 16'h0001);
      code_in = encode(rp) ^ bitmask(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("sat_small_cnt", sat_corr_cnt, 2'd3);
    check("sat_main_cnt", corr_cnt, 8'd5);
    code_in  = encode(16'h0F0F) ^ bitmask(12);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_word", {out_valid, corrected, data_out}, {1'b1, 1'b1, 16'h0F0F});
    check("clr_priority", {corr_cnt, sat_corr_cnt}, '0);
    tick(); tick();

    // ---------------- randomized run against the reference decoder
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    expq.delete();
    exp_cc = 0; exp_uc = 0; nack_seen = 0; stall_prev = 1'b0;
    prev_data = '0; prev_corr = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      rp  = DW'($urandom);
      rcw = encode(rp);
      rr  = $urandom_range(0, 99);
      if (rr >= 50) begin
        p0 = $urandom_range(0, CW - 1);
        rcw = rcw ^ bitmask(p0);
        if (rr >= 85) begin
          p1 = (p0 + $urandom_range(1, CW - 1)) % CW;
          rcw = rcw ^ bitmask(p1);
        end
      end
      code_in = rcw;
      #1;
      if (stall_prev)
        check($sformatf("rnd_hold%0d", cyc), {out_valid, corrected, data_out}, {1'b1, prev_corr, prev_data});
      if (nack) nack_seen++;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        if (expq.size() == 0) begin
          check($sformatf("rnd_unexpected%0d", cyc), {out_valid, data_out}, '0);
        end else begin
          e = expq.pop_front();
          check($sformatf("rnd_out%0d", cyc), {corrected, data_out}, e);
        end
      end
      if (acc) begin
        ref_decode(rcw, rdrop, rcorr, rdata);
        if (rdrop) exp_uc++;
        else begin
          expq.push_back({rcorr, rdata});
          if (rcorr) exp_cc++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = data_out;
      prev_corr  = corrected;
      tick();
    end
    check("rnd_queue_empty", expq.size(), 0);
    check("rnd_nack_count", nack_seen, exp_uc);
    check("rnd_corr_cnt", corr_cnt, (exp_cc > 255) ? 255 : exp_cc);
    check("rnd_uncorr_cnt", uncorr_cnt, (exp_uc > 255) ? 255 : exp_uc);
    check("rnd_sat_corr_cnt", sat_corr_cnt, (exp_cc > 3) ? 3 : exp_cc);
    check("rnd_sat_uncorr_cnt", sat_uncorr_cnt, (exp_uc > 3) ? 3 : exp_uc);

    // ---------------- reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = encode(16'hBEEF) ^ bitmask(3);
    tick();
    code_in   = encode(16'hCAFE);
    tick();
    in_valid  = 1'b0;
    #1;
    check("rstmid_full", {out_valid, in_ready}, 2'b10);
    #1 reset = 1'b1;
    #1;
    check("rstmid_main", {out_valid, corrected, nack, data_out, corr_cnt, uncorr_cnt, in_ready}, 1);
    check("rstmid_sat", {sat_out_valid, sat_corrected, sat_nack, sat_data_out,
                         sat_corr_cnt, sat_uncorr_cnt, sat_in_ready}, 1);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid || nack) ov_seen++;
    end
    check("rstmid_no_emit", ov_seen, 0);
    check("rstmid_in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
